// File: rtl/bus_source_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_source_arbiter: round-robin owner of the 4:1 A09 bus mux select lines.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bus_source_arbiter #(
  parameter int MaxHold    = 16,
  parameter int CountWidth = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Req,
  input  logic       Ack,
  output logic [1:0] Select,
  output logic [3:0] Grant,
  output logic       Valid,
  output logic       Timeout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CountWidth-1:0] HOLD_LAST = CountWidth'(MaxHold - 1);

  logic [0:0]            state_q,   state_d;
  logic [1:0]            ptr_q,     ptr_d;
  logic [CountWidth-1:0] cnt_q,     cnt_d;
  logic [1:0]            sel_q,     sel_d;
  logic [3:0]            grant_q,   grant_d;
  logic                  valid_q,   valid_d;
  logic                  timeout_q, timeout_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;

  // Rotating search starting at the pointer; first asserted request wins.
  always_comb begin
    winner = ptr_q;
    idx    = ptr_q;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && Req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          sel_d   = winner;
          grant_d = 4'b0001 << winner;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        // Completion and withdrawal outrank the hold timeout.
        if (Ack || !Req[sel_q] || (cnt_q == HOLD_LAST)) begin
          state_d   = ST_IDLE;
          grant_d   = 4'b0000;
          valid_d   = 1'b0;
          ptr_d     = sel_q + 2'd1;
          timeout_d = !Ack && Req[sel_q];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      sel_q     <= 2'd0;
      grant_q   <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign Select  = sel_q;
  assign Grant   = grant_q;
  assign Valid   = valid_q;
  assign Timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_source_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bus_source_arbiter: directed stimulus with a transaction scoreboard.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bus_source_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       vld;
  logic       tmo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] sel;
    int         dur;
    logic       to;
    logic       by_rst;
  } exp_t;

  exp_t sb[$];

  bus_source_arbiter #(.MaxHold(16), .CountWidth(5)) dut (
    .Clk(clk), .Reset(rst), .Req(req), .Ack(ack),
    .Select(sel), .Grant(gnt), .Valid(vld), .Timeout(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input logic [1:0] s, input int d, input logic t, input logic r);
    exp_t e;
    e.sel = s; e.dur = d; e.to = t; e.by_rst = r;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_grant"},   int'(gnt), 0);
    check({tag, "_valid"},   int'(vld), 0);
    check({tag, "_select"},  int'(sel), 0);
    check({tag, "_timeout"}, int'(tmo), 0);
  endtask

  // Monitor: builds each grant as a transaction and scores it when Valid falls.
  logic       in_txn = 1'b0;
  logic [1:0] cur_sel;
  int         dur;
  logic       gnt_ok;
  always @(negedge clk) begin
    logic ended;
    exp_t e;
    ended = 1'b0;
    if (vld) begin
      if (!in_txn) begin
        in_txn  = 1'b1;
        cur_sel = sel;
        dur     = 1;
        gnt_ok  = (gnt == (4'b0001 << sel));
      end else begin
        dur++;
        gnt_ok = gnt_ok && (sel == cur_sel) && (gnt == (4'b0001 << sel));
      end
    end else if (in_txn) begin
      in_txn = 1'b0;
      ended  = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_txn: got select %0d dur %0d expected none", cur_sel, dur);
      end else begin
        e = sb.pop_front();
        check("txn_select",   int'(cur_sel), int'(e.sel));
        check("txn_duration", dur, e.dur);
        check("txn_onehot",   int'(gnt_ok), 1);
        check("txn_timeout",  int'(tmo), int'(e.to));
        check("txn_grant_drop", int'(gnt), 0);
        check("txn_select_after", int'(sel), e.by_rst ? 0 : int'(e.sel));
      end
    end
    if (!ended && tmo) begin
      checks++;
      errors++;
      $display("FAIL stray_timeout: got 1 expected 0 at %0t", $time);
    end
  end

  initial begin
    rst = 1'b1; req = 4'b1111; ack = 1'b0;
    // Reset held for two edges with all requests up.
    tick(); tick();
    check_idle_outputs("reset");

    // Round robin 0,1,2,3,0 with Ack always high (single-cycle transfers).
    rst = 1'b0; ack = 1'b1;
    expect_txn(2'd0, 1, 1'b0, 1'b0);
    expect_txn(2'd1, 1, 1'b0, 1'b0);
    expect_txn(2'd2, 1, 1'b0, 1'b0);
    expect_txn(2'd3, 1, 1'b0, 1'b0);
    expect_txn(2'd0, 1, 1'b0, 1'b0);
    repeat (10) tick();
    req = 4'b0000;

    // Move pointer to 2 via source 1, then skip-and-wrap.
    req = 4'b0010;
    expect_txn(2'd1, 1, 1'b0, 1'b0);
    tick(); tick();
    req = 4'b0011;
    expect_txn(2'd0, 1, 1'b0, 1'b0);
    tick(); tick();
    req = 4'b0010;
    expect_txn(2'd1, 1, 1'b0, 1'b0);
    tick(); tick();
    req = 4'b0000; ack = 1'b0;
    tick();

    // Timeout from Ptr=2, regrant to source 2, then Ack on the timeout edge.
    req = 4'b0100;
    expect_txn(2'd2, 16, 1'b1, 1'b0);
    expect_txn(2'd2, 16, 1'b0, 1'b0);
    repeat (33) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0; req = 4'b0000;
    tick();

    // Ptr=3: source 0 wins, withdraws after three valid cycles.
    req = 4'b0001;
    expect_txn(2'd0, 3, 1'b0, 1'b0);
    tick(); tick(); tick();
    req = 4'b0000;
    tick();
    tick();

    // Ptr=1: source 3 granted, reset lands mid-grant.
    req = 4'b1000;
    expect_txn(2'd3, 2, 1'b0, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("midreset");

    // After reset Ptr=0, so the lowest requester wins.
    rst = 1'b0; req = 4'b1010;
    expect_txn(2'd1, 1, 1'b0, 1'b0);
    @(posedge clk); #1;
    ack = 1'b1;
    tick();
    ack = 1'b0; req = 4'b0000;
    repeat (4) tick();

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
